// File: rtl/hdrgen_pkg.sv
// Shared constants, FSM encoding, beat bundle and byte
// substitution helper for the header stream generator.
package hdrgen_pkg;

    // Template word fields
    localparam int EOP_BIT = 9;
    localparam int SUB_BIT = 8;

    // Substitution codes carried in the low byte
    localparam logic [7:0] SUB_LEN1_HI = 8'h00;
    localparam logic [7:0] SUB_LEN1_LO = 8'h01;
    localparam logic [7:0] SUB_CSUM_HI = 8'h02;
    localparam logic [7:0] SUB_CSUM_LO = 8'h03;
    localparam logic [7:0] SUB_LEN2_HI = 8'h04;
    localparam logic [7:0] SUB_LEN2_LO = 8'h05;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CSUM,
        S_STREAM
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    function automatic logic [7:0] subst_byte(
        input logic [7:0]  code,
        input logic [15:0] len1,
        input logic [15:0] len2,
        input logic [15:0] csum
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (code)
            SUB_LEN1_HI: b = len1[15:8];
            SUB_LEN1_LO: b = len1[7:0];
            SUB_CSUM_HI: b = csum[15:8];
            SUB_CSUM_LO: b = csum[7:0];
            SUB_LEN2_HI: b = len2[15:8];
            SUB_LEN2_LO: b = len2[7:0];
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hdrgen_csum16.sv
// Ones-complement add of two 16-bit words, end-around fold, invert.
// Ports: base, addend (in, 16) -> csum (out, 16).
module hdrgen_csum16 (
    input  logic [15:0] base,
    input  logic [15:0] addend,
    output logic [15:0] csum
);

    logic [16:0] sum;
    logic [15:0] fold;

    assign sum  = {1'b0, base} + {1'b0, addend};
    // A 17-bit sum folds back without a second carry
    assign fold = sum[15:0] + {15'd0, sum[16]};
    assign csum = ~fold;

endmodule

// File: rtl/header_stream_generator.sv
// Streams a per-channel header from a template RAM, one byte per beat,
// with length and checksum substitution. Ports: start/ch/body_length
// request, busy, out_* valid/ready byte stream, tpl_*/off1_*/off2_*/
// csb_* management writes; clk, rst (async active-low).
module header_stream_generator
    import hdrgen_pkg::*;
#(
    parameter  int NUM_CH    = 16,
    parameter  int HDR_BYTES = 64,
    parameter  int TPL_W     = 10,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int HB_W      = $clog2(HDR_BYTES),
    localparam int TA_W      = CH_W + HB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CH_W-1:0]  ch,
    input  logic [15:0]      body_length,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             tpl_we,
    input  logic [TA_W-1:0]  tpl_addr,
    input  logic [TPL_W-1:0] tpl_wdata,
    input  logic             off1_we,
    input  logic [CH_W-1:0]  off1_addr,
    input  logic [15:0]      off1_wdata,
    input  logic             off2_we,
    input  logic [CH_W-1:0]  off2_addr,
    input  logic [15:0]      off2_wdata,
    input  logic             csb_we,
    input  logic [CH_W-1:0]  csb_addr,
    input  logic [15:0]      csb_wdata
);

    state_t state_q, state_d;

    logic [15:0] off1_tbl [NUM_CH];
    logic [15:0] off2_tbl [NUM_CH];
    logic [15:0] csb_tbl  [NUM_CH];

    logic [TPL_W-1:0] tpl_mem [NUM_CH*HDR_BYTES];
    logic [TPL_W-1:0] rdata;

    logic [CH_W-1:0] ch_q;
    logic [15:0] blen_q, off1_q, off2_q, csb_q;
    logic [15:0] len1_q, len2_q, csum_q, csum_d;

    logic [HB_W-1:0] rd_idx, p1_idx;
    logic rd_all, rd_en, p1_v, eop_seen;
    logic out_v, skid_v;
    beat_t p1_beat, skid_q, out_q;

    logic accept, xfer, done, p1_live, room, stop;
    logic [1:0] occ;

    assign accept  = (state_q == S_IDLE) & start;
    assign xfer    = out_v & out_ready;
    assign done    = xfer & out_q.eop;
    // Reads issued past the eop are still landing; discard them
    assign p1_live = p1_v & ~eop_seen;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_CALC;
            S_CALC:   state_d = S_CSUM;
            S_CSUM:   state_d = S_STREAM;
            S_STREAM: if (done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Issue a read only if its data fits in out + skid even
    // when the next cycle stalls.
    always_comb begin
        occ  = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, p1_live};
        room = (occ - {1'b0, xfer}) <= 2'd1;
        stop = eop_seen | rd_all | (p1_live & p1_beat.eop);
        rd_en = 1'b0;
        if (state_q == S_CSUM)
            rd_en = 1'b1;
        else if (state_q == S_STREAM)
            rd_en = room & ~stop;
    end

    // ---------------- Tables ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                off1_tbl[i] <= '0;
                off2_tbl[i] <= '0;
                csb_tbl[i]  <= '0;
            end
        end else begin
            if (off1_we) off1_tbl[off1_addr] <= off1_wdata;
            if (off2_we) off2_tbl[off2_addr] <= off2_wdata;
            if (csb_we)  csb_tbl[csb_addr]   <= csb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (tpl_we) tpl_mem[tpl_addr] <= tpl_wdata;
        if (rd_en)  rdata <= tpl_mem[{ch_q, rd_idx}];
    end

    // ---------------- Snapshot and arithmetic ----------------
    hdrgen_csum16 u_csum (
        .base   (csb_q),
        .addend (len1_q),
        .csum   (csum_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q   <= '0;
            blen_q <= '0;
            off1_q <= '0;
            off2_q <= '0;
            csb_q  <= '0;
            len1_q <= '0;
            len2_q <= '0;
            csum_q <= '0;
        end else begin
            if (accept) begin
                ch_q   <= ch;
                blen_q <= body_length;
                off1_q <= off1_tbl[ch];
                off2_q <= off2_tbl[ch];
                csb_q  <= csb_tbl[ch];
            end
            if (state_q == S_CALC) begin
                len1_q <= blen_q + off1_q;
                len2_q <= blen_q + off2_q;
            end
            if (state_q == S_CSUM) csum_q <= csum_d;
        end
    end

    // ---------------- Read pipeline ----------------
    always_comb begin
        p1_beat.data = rdata[7:0];
        if (rdata[SUB_BIT])
            p1_beat.data = subst_byte(rdata[7:0], len1_q, len2_q, csum_q);
        p1_beat.sop = (p1_idx == '0);
        p1_beat.eop = rdata[EOP_BIT] | (&p1_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx <= '0;
            rd_all <= 1'b0;
            p1_idx <= '0;
            p1_v   <= 1'b0;
        end else begin
            if (accept) begin
                rd_idx <= '0;
                rd_all <= 1'b0;
            end else if (rd_en) begin
                rd_idx <= rd_idx + 1'b1;
                if (&rd_idx) rd_all <= 1'b1;
            end
            p1_v   <= rd_en;
            p1_idx <= rd_idx;
        end
    end

    // ---------------- Output register + skid ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v    <= 1'b0;
            out_q    <= '0;
            skid_v   <= 1'b0;
            skid_q   <= '0;
            eop_seen <= 1'b0;
        end else if (state_q != S_STREAM || done) begin
            out_v    <= 1'b0;
            out_q    <= '0;
            skid_v   <= 1'b0;
            eop_seen <= 1'b0;
        end else begin
            eop_seen <= eop_seen | (p1_live & p1_beat.eop);
            if (!out_v || out_ready) begin
                if (skid_v) begin
                    out_v  <= 1'b1;
                    out_q  <= skid_q;
                    skid_v <= p1_live;
                    skid_q <= p1_beat;
                end else if (p1_live) begin
                    out_v <= 1'b1;
                    out_q <= p1_beat;
                end else begin
                    out_v <= 1'b0;
                    out_q <= '0;
                end
            end else if (p1_live) begin
                skid_v <= 1'b1;
                skid_q <= p1_beat;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_v;
    assign out_data  = out_q.data;
    assign out_sop   = out_q.sop;
    assign out_eop   = out_q.eop;

endmodule
